// File: rtl/ram8_reader.sv
// ram8_reader: scans DEPTH words of a combinational-read memory and streams
// them out over a valid/ready handshake, one word every two cycles at best.
// Optional feature macro: RAM8_READER_CHECKSUM_EN appends a modulo-2^WIDTH
// sum of the transferred words as one extra word at the end of each scan.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   start                request one full scan (sampled only when idle)
//   rd_addr / rd_data    memory address out / read data in
//   out_data, out_valid  word offered to the consumer
//   out_ready            consumer accepts out_data
//   busy                 high in every state except IDLE
//   done                 one-cycle pulse at the end of a scan
module ram8_reader #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    PRESENT = 3'd2,
    DONE    = 3'd3
`ifdef RAM8_READER_CHECKSUM_EN
    ,
    CSUM    = 3'd4
`endif
  } state_t;

  state_t state;

`ifdef RAM8_READER_CHECKSUM_EN
  logic [WIDTH-1:0] sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef RAM8_READER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= READ;
`ifdef RAM8_READER_CHECKSUM_EN
            sum     <= '0;
`endif
          end
        end
        READ: begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
`ifdef RAM8_READER_CHECKSUM_EN
            sum       <= sum + out_data;
`endif
            if (rd_addr == LAST) begin
`ifdef RAM8_READER_CHECKSUM_EN
              state <= CSUM;
`else
              state <= DONE;
              done  <= 1'b1;
`endif
            end else begin
              rd_addr <= rd_addr + 1'b1;
              state   <= READ;
            end
          end
        end
`ifdef RAM8_READER_CHECKSUM_EN
        // First cycle loads the sum (mirrors READ), then it is
        // held under the same handshake as a data word.
        CSUM: begin
          if (!out_valid) begin
            out_data  <= sum;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= DONE;
            done      <= 1'b1;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_reader.sv
// tb_ram8_reader: randomized self-checking bench for ram8_reader.
// Expected streams come from a queue model of the memory contents.
module tb_ram8_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [15:0] mem [8];

  int nchecks = 0;
  int nerrors = 0;

  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  int          done_edge;
  int          done_cnt;
  bit          timeout;

`ifdef RAM8_READER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  assign rd_data = mem[rd_addr];

  always #5 clk = ~clk;

  ram8_reader #(
    .WIDTH (16),
    .DEPTH (8),
    .ADDR_W(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  // Model: every word in address order, then (optionally) their
  // sum modulo 2^16.
  task automatic build_expected();
    int s;
    s = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mem[i]);
      s = (s + int'(mem[i])) % 65536;
    end
    if (CSUM_ON) exp_q.push_back(16'(s));
  endtask

  // Pulse start and collect every handshake until busy drops.
  // Edge 0 is the start edge; done_edge counts edges after it.
  task automatic run_scan(input bit rnd, input bit hold_start);
    int edges;
    edges = 0;
    done_edge = -1;
    done_cnt = 0;
    timeout = 1'b1;
    got.delete();
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = edges;
      end
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && out_ready) got.push_back(out_data);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchecks++;
    if ({busy, done, out_valid, rd_addr, out_data} !== 22'd0) begin
      nerrors++;
      $display("FAIL reset_outputs: busy=%b done=%b vld=%b addr=%0d data=%h want all 0",
               busy, done, out_valid, rd_addr, out_data);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    nchecks++;
    if (busy !== 1'b0) begin
      nerrors++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_directed_scan();
    for (int i = 0; i < 8; i++) mem[i] = 16'(i + 1);
    build_expected();
    run_scan(1'b0, 1'b0);
    nchecks++;
    if (timeout !== 1'b0) begin
      nerrors++;
      $display("FAIL dir_timeout: scan did not end within budget");
    end
    nchecks++;
    if (got.size() != exp_q.size()) begin
      nerrors++;
      $display("FAIL dir_count: got %0d words want %0d",
               got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (got[i] !== exp_q[i]) begin
        nerrors++;
        $display("FAIL dir_word%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    nchecks++;
    if (done_edge != (CSUM_ON ? 18 : 16)) begin
      nerrors++;
      $display("FAIL dir_done_edge: got %0d want %0d",
               done_edge, CSUM_ON ? 18 : 16);
    end
    nchecks++;
    if (done_cnt != 1) begin
      nerrors++;
      $display("FAIL dir_done_width: got %0d cycles want 1", done_cnt);
    end
    nchecks++;
    if (rd_addr !== 3'd7) begin
      nerrors++;
      $display("FAIL dir_addr_hold: got %0d want 7", rd_addr);
    end
  endtask

  task automatic test_backpressure();
    int stalls;
    int c;
    for (int i = 0; i < 8; i++) mem[i] = 16'(i + 1);
    build_expected();
    got.delete();
    stalls = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < 400 && busy; c++) begin
      out_ready = 1'b1;
      if (out_valid && got.size() == 2 && stalls < 5) begin
        nchecks++;
        if (out_data !== 16'd3) begin
          nerrors++;
          $display("FAIL bp_hold%0d: data %h want 0003", stalls, out_data);
        end
        out_ready = 1'b0;
        mem[2] = 16'hBEEF;
        stalls++;
      end
      if (out_valid && out_ready) begin
        mem[2] = 16'd3;
        got.push_back(out_data);
      end
      @(posedge clk);
      @(negedge clk);
      if (stalls > 0 && stalls <= 5 && got.size() == 2) begin
        nchecks++;
        if (out_valid !== 1'b1) begin
          nerrors++;
          $display("FAIL bp_valid%0d: got %b want 1", stalls, out_valid);
        end
      end
    end
    nchecks++;
    if (c >= 400 || stalls != 5) begin
      nerrors++;
      $display("FAIL bp_progress: stalls %0d want 5 busy %b", stalls, busy);
    end
    nchecks++;
    if (got.size() != exp_q.size()) begin
      nerrors++;
      $display("FAIL bp_count: got %0d want %0d",
               got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (got[i] !== exp_q[i]) begin
        nerrors++;
        $display("FAIL bp_word%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int c;
    for (int i = 0; i < 8; i++) mem[i] = 16'(i + 1);
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < 100; c++) begin
      if (out_valid && out_data == 16'd5) break;
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nchecks++;
    if (c >= 100 || out_valid !== 1'b0 || rd_addr !== 3'd0 ||
        busy !== 1'b0 || done !== 1'b0 || out_data !== 16'd0) begin
      nerrors++;
      $display("FAIL rst_mid: vld=%b addr=%0d busy=%b done=%b data=%h want 0s",
               out_valid, rd_addr, busy, done, out_data);
    end
    reset = 1'b0;
    start = 1'b0;
    build_expected();
    run_scan(1'b0, 1'b0);
    nchecks++;
    if (timeout !== 1'b0 || got.size() != exp_q.size()) begin
      nerrors++;
      $display("FAIL rst_rescan_count: got %0d want %0d",
               got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (got[i] !== exp_q[i]) begin
        nerrors++;
        $display("FAIL rst_word%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    build_expected();
    run_scan(1'b1, 1'b1);
    nchecks++;
    if (timeout !== 1'b0 || done_cnt != 1) begin
      nerrors++;
      $display("FAIL restart_done: done pulses %0d want 1", done_cnt);
    end
    nchecks++;
    if (got.size() != exp_q.size()) begin
      nerrors++;
      $display("FAIL restart_count: got %0d want %0d",
               got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (got[i] !== exp_q[i]) begin
        nerrors++;
        $display("FAIL restart_word%0d: got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
      build_expected();
      run_scan(1'b1, 1'b0);
      nchecks++;
      if (timeout !== 1'b0 || done_cnt != 1 ||
          got.size() != exp_q.size()) begin
        nerrors++;
        $display("FAIL rand%0d_count: got %0d words %0d dones want %0d/1",
                 t, got.size(), done_cnt, exp_q.size());
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        nchecks++;
        if (got[i] !== exp_q[i]) begin
          nerrors++;
          $display("FAIL rand%0d_word%0d: got %h want %h",
                   t, i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) mem[i] = 16'hFFFF;
    build_expected();
    run_scan(1'b0, 1'b0);
    nchecks++;
    if (got.size() != exp_q.size()) begin
      nerrors++;
      $display("FAIL wrap_count: got %0d want %0d",
               got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nchecks++;
      if (got[i] !== exp_q[i]) begin
        nerrors++;
        $display("FAIL wrap_word%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    test_reset();
    test_directed_scan();
    test_backpressure();
    test_reset_mid_scan();
    test_start_ignored();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule
